sc_multi_fsm: RTL and testbench

Multi-channel charging controller. Runs one charging state machine per charger port against a shared grid-quality input. Adds three things per channel: a relay-settle delay before charge current is enabled, a grid-stable hold-off before leaving WAIT, and a latched fault that clears only on explicit request. A global slot limit caps how many channels charge at once. Sits between the grid monitor/classifier and the per-port actuators.

---
 rtl/sc_multi_fsm_pkg.sv | 26 ++
 rtl/sc_multi_fsm_ch_fsm.sv | 96 +++++++++
 rtl/sc_multi_fsm.sv | 77 +++++++
 tb/tb_sc_multi_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_multi_fsm_pkg.sv
// Shared types for the multi-channel charging controller.
package sc_multi_fsm_pkg;

    // Per-channel controller state. Codes 5..7 are illegal and recover to FAULT.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK_GRID = 3'd1,
        ST_CHARGING   = 3'd2,
        ST_WAIT       = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    // Grid class from the upstream classifier. Code 3 is handled like CRITICAL.
    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2,
        GRID_CRIT_ALT = 2'd3
    } grid_state_t;

    // Both upper codes mean "trip now".
    function automatic logic grid_is_critical(input grid_state_t g);
        return g[1];
    endfunction

endpackage

// File: rtl/sc_multi_fsm_ch_fsm.sv
// One charger channel: state register, grid hold-off counter, relay settle counter.
module sc_ch_fsm
    import sc_multi_fsm_pkg::*;
#(
    parameter int HOLDOFF_CYC  = 8,
    parameter int RELAY_SETTLE = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_grant,
    input  grid_state_t i_grid,
    input  logic        i_conn,
    input  logic        i_full,
    input  logic        i_fault_clr,
    output state_t      o_state,
    output logic        o_relay,
    output logic        o_charge_en,
    output logic        o_req
);

    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    // Keep the settle counter at least one bit wide so RELAY_SETTLE=0 still builds.
    localparam int SW = (RELAY_SETTLE < 1) ? 1 : $clog2(RELAY_SETTLE + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLDOFF_CYC);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(RELAY_SETTLE);

    state_t        r_state, w_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic [SW-1:0] r_settle, w_settle_next;
    logic          w_crit, w_normal, w_unstable;

    assign w_crit     = grid_is_critical(i_grid);
    assign w_normal   = (i_grid == GRID_NORMAL);
    assign w_unstable = (i_grid == GRID_UNSTABLE);

    // Next-state and hold-off counter; CRITICAL overrides every state.
    always_comb begin
        w_next      = r_state;
        w_hold_next = '0;
        if (w_crit) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_conn && !i_full) w_next = ST_CHECK_GRID;
                end
                ST_CHECK_GRID: begin
                    if (!i_conn)         w_next = ST_IDLE;
                    else if (w_unstable) w_next = ST_WAIT;
                    else if (i_grant)    w_next = ST_CHARGING;
                end
                ST_CHARGING: begin
                    if (!i_conn || i_full) w_next = ST_IDLE;
                    else if (w_unstable)   w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // Counter is compared registered: the exit edge follows the
                    // edge that recorded the last required NORMAL cycle.
                    if (r_hold == HOLD_MAX) w_next = ST_IDLE;
                    else if (w_normal)      w_hold_next = r_hold + HW'(1);
                end
                ST_FAULT: begin
                    if (i_fault_clr) w_next = ST_IDLE;
                end
                default: w_next = ST_FAULT;
            endcase
        end
    end

    // Settle counter restarts on CHARGING entry and saturates at RELAY_SETTLE.
    always_comb begin
        w_settle_next = '0;
        if (w_next == ST_CHARGING && r_state == ST_CHARGING) begin
            w_settle_next = (r_settle == SETTLE_MAX) ? r_settle : r_settle + SW'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_hold   <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_next;
            r_hold   <= w_hold_next;
            r_settle <= w_settle_next;
        end
    end

    assign o_state     = r_state;
    assign o_relay     = (r_state == ST_CHARGING);
    assign o_charge_en = (r_state == ST_CHARGING) && (r_settle == SETTLE_MAX);
    assign o_req       = (r_state == ST_CHECK_GRID) && w_normal;

endmodule

// File: rtl/sc_multi_fsm.sv
// Multi-channel charging controller: per-channel FSMs plus shared slot arbitration.
module sc_multi_fsm
    import sc_multi_fsm_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int MAX_ACTIVE   = 2,
    parameter int HOLDOFF_CYC  = 8,
    parameter int RELAY_SETTLE = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [1:0]                  grid_state,
    input  logic [N_CH-1:0]             battery_connected,
    input  logic [N_CH-1:0]             battery_full,
    input  logic [N_CH-1:0]             fault_clr,
    output logic [3*N_CH-1:0]           ch_state,
    output logic [N_CH-1:0]             relay_activation,
    output logic [N_CH-1:0]             charge_enable,
    output logic [$clog2(N_CH+1)-1:0]   active_cnt
);

    localparam int CW = $clog2(N_CH + 1);

    grid_state_t     w_grid;
    state_t          w_st [N_CH];
    logic [N_CH-1:0] w_relay, w_req, w_grant;
    logic [CW-1:0]   w_cnt, w_free, w_given;

    assign w_grid = grid_state_t'(grid_state);

    // Charging channels counted from registered state, so a channel leaving
    // CHARGING still holds its slot during the cycle it leaves.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt = w_cnt + CW'(w_relay[i]);
        end
    end

    assign w_free = CW'(MAX_ACTIVE) - w_cnt;

    // Fixed-priority grant: lowest-indexed requesters take the free slots.
    always_comb begin
        w_grant = '0;
        w_given = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_req[i] && (w_given < w_free)) begin
                w_grant[i] = 1'b1;
                w_given    = w_given + CW'(1);
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sc_ch_fsm #(
            .HOLDOFF_CYC  (HOLDOFF_CYC),
            .RELAY_SETTLE (RELAY_SETTLE)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_grant     (w_grant[g]),
            .i_grid      (w_grid),
            .i_conn      (battery_connected[g]),
            .i_full      (battery_full[g]),
            .i_fault_clr (fault_clr[g]),
            .o_state     (w_st[g]),
            .o_relay     (w_relay[g]),
            .o_charge_en (charge_enable[g]),
            .o_req       (w_req[g])
        );
        assign ch_state[3*g +: 3] = w_st[g];
    end

    assign relay_activation = w_relay;
    assign active_cnt       = w_cnt;

endmodule

// File: tb/tb_sc_multi_fsm.sv
// Self-checking bench for sc_multi_fsm: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_sc_multi_fsm;

    localparam int NC = 4;
    localparam int MA = 2;
    localparam int HO = 8;
    localparam int RS = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  grid_state = 2'd0;
    logic [3:0]  conn = '0, full = '0, clr = '0;
    logic [11:0] ch_state;
    logic [3:0]  relay, ce;
    logic [2:0]  active_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 IDLE, 1 CHECK_GRID, 2 CHARGING, 3 WAIT, 4 FAULT.
    int m_st   [NC];
    int m_hold [NC];
    int m_age  [NC];   // full cycles spent in CHARGING since entry

    always #5 clk = ~clk;

    sc_multi_fsm #(
        .N_CH(NC), .MAX_ACTIVE(MA), .HOLDOFF_CYC(HO), .RELAY_SETTLE(RS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .grid_state        (grid_state),
        .battery_connected (conn),
        .battery_full      (full),
        .fault_clr         (clr),
        .ch_state          (ch_state),
        .relay_activation  (relay),
        .charge_enable     (ce),
        .active_cnt        (active_cnt)
    );

    typedef struct {
        logic [1:0]  g;
        logic [3:0]  c, f, r;
        logic [11:0] e_st;
        logic [3:0]  e_rl, e_ce;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_st[i] = 0; m_hold[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] g, input logic [3:0] c, f, r);
        int nst [NC];
        int busy, free;
        busy = 0;
        for (int i = 0; i < NC; i++) if (m_st[i] == 2) busy++;
        free = MA - busy;
        for (int i = 0; i < NC; i++) begin
            nst[i] = m_st[i];
            if (g >= 2) nst[i] = 4;
            else case (m_st[i])
                0: if (c[i] && !f[i]) nst[i] = 1;
                1: if (!c[i]) nst[i] = 0;
                   else if (g == 1) nst[i] = 3;
                   else if (free > 0) begin nst[i] = 2; free--; end
                2: if (!c[i] || f[i]) nst[i] = 0;
                   else if (g == 1) nst[i] = 3;
                3: if (m_hold[i] >= HO) nst[i] = 0;
                4: if (r[i]) nst[i] = 0;
                default: nst[i] = 4;
            endcase
        end
        for (int i = 0; i < NC; i++) begin
            m_hold[i] = (m_st[i] == 3 && nst[i] == 3) ? ((g == 0) ? m_hold[i] + 1 : 0) : 0;
            m_age[i]  = (m_st[i] == 2 && nst[i] == 2) ? m_age[i] + 1 : 0;
            m_st[i]   = nst[i];
        end
    endtask

    task automatic chk_model(input string tag);
        logic [11:0] es;
        logic [3:0]  er, ec;
        int          cnt;
        es = '0; er = '0; ec = '0; cnt = 0;
        for (int i = 0; i < NC; i++) begin
            es[3*i +: 3] = 3'(m_st[i]);
            er[i] = (m_st[i] == 2);
            ec[i] = (m_st[i] == 2) && (m_age[i] >= RS);
            if (m_st[i] == 2) cnt++;
        end
        chk({tag, ".state"}, 32'(ch_state), 32'(es));
        chk({tag, ".relay"}, 32'(relay), 32'(er));
        chk({tag, ".ce"},    32'(ce), 32'(ec));
        chk({tag, ".cnt"},   32'(active_cnt), 32'(cnt));
    endtask

    // Apply inputs between edges, advance the model, sample 1ns after the edge.
    task automatic step(input logic [1:0] g, input logic [3:0] c, f, r);
        grid_state = g; conn = c; full = f; clr = r;
        model_step(g, c, f, r);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        grid_state = 2'd0; conn = '0; full = '0; clr = '0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk({tag, ".rst_state"}, 32'(ch_state), 32'h0);
        chk({tag, ".rst_relay"}, 32'(relay), 32'h0);
        chk({tag, ".rst_ce"},    32'(ce), 32'h0);
        chk({tag, ".rst_cnt"},   32'(active_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        // {grid, conn, full, clr, exp state, exp relay, exp ce, exp cnt}
        vt[0]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h001, 4'b0000, 4'b0000, 3'd0};
        vt[1]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h002, 4'b0001, 4'b0000, 3'd1};
        vt[2]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h002, 4'b0001, 4'b0000, 3'd1};
        vt[3]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h002, 4'b0001, 4'b0000, 3'd1};
        vt[4]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h002, 4'b0001, 4'b0001, 3'd1};
        vt[5]  = '{2'd0, 4'b0001, 4'b0000, 4'b0000, 12'h002, 4'b0001, 4'b0001, 3'd1};
        vt[6]  = '{2'd0, 4'b0001, 4'b0001, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0};
        vt[7]  = '{2'd0, 4'b1111, 4'b0000, 4'b0000, 12'h249, 4'b0000, 4'b0000, 3'd0};
        vt[8]  = '{2'd0, 4'b1111, 4'b0000, 4'b0000, 12'h252, 4'b0011, 4'b0000, 3'd2};
        vt[9]  = '{2'd0, 4'b1111, 4'b0000, 4'b0000, 12'h252, 4'b0011, 4'b0000, 3'd2};
        vt[10] = '{2'd0, 4'b1111, 4'b0001, 4'b0000, 12'h250, 4'b0010, 4'b0000, 3'd1};
        vt[11] = '{2'd0, 4'b1111, 4'b0001, 4'b0000, 12'h290, 4'b0110, 4'b0010, 3'd2};
        vt[12] = '{2'd0, 4'b1111, 4'b0001, 4'b0000, 12'h290, 4'b0110, 4'b0010, 3'd2};

        // Table: single-channel bring-up, then four requesters against two slots.
        do_reset("tbl");
        for (int k = 0; k < 13; k++) begin
            step(vt[k].g, vt[k].c, vt[k].f, vt[k].r);
            chk($sformatf("tbl[%0d].state", k), 32'(ch_state), 32'(vt[k].e_st));
            chk($sformatf("tbl[%0d].relay", k), 32'(relay), 32'(vt[k].e_rl));
            chk($sformatf("tbl[%0d].ce", k),    32'(ce), 32'(vt[k].e_ce));
            chk($sformatf("tbl[%0d].cnt", k),   32'(active_cnt), 32'(vt[k].e_cnt));
        end

        // WAIT hold-off: an interrupted NORMAL run restarts the count.
        do_reset("wait");
        step(2'd0, 4'b0001, 4'b0000, 4'b0000);
        step(2'd0, 4'b0001, 4'b0000, 4'b0000);
        step(2'd1, 4'b0001, 4'b0000, 4'b0000);
        chk("wait.enter", 32'(ch_state[2:0]), 32'd3);
        chk("wait.relay_low", 32'(relay), 32'h0);
        chk("wait.ce_low", 32'(ce), 32'h0);
        for (int k = 0; k < 7; k++) begin
            step(2'd0, 4'b0001, 4'b0000, 4'b0000);
            chk("wait.run7", 32'(ch_state[2:0]), 32'd3);
        end
        step(2'd1, 4'b0001, 4'b0000, 4'b0000);
        chk("wait.break", 32'(ch_state[2:0]), 32'd3);
        for (int k = 0; k < 8; k++) begin
            step(2'd0, 4'b0001, 4'b0000, 4'b0000);
            chk("wait.run8", 32'(ch_state[2:0]), 32'd3);
        end
        step(2'd0, 4'b0001, 4'b0000, 4'b0000);
        chk("wait.exit_idle", 32'(ch_state[2:0]), 32'd0);
        chk_model("wait.model");

        // CRITICAL trips every channel; only an explicit clear releases one.
        do_reset("crit");
        step(2'd0, 4'b0011, 4'b0000, 4'b0000);
        step(2'd0, 4'b0011, 4'b0000, 4'b0000);
        chk("crit.pre_cnt", 32'(active_cnt), 32'd2);
        step(2'd2, 4'b0011, 4'b0000, 4'b0000);
        chk("crit.all_fault", 32'(ch_state), 32'h924);
        chk("crit.relay", 32'(relay), 32'h0);
        chk("crit.ce", 32'(ce), 32'h0);
        chk("crit.cnt", 32'(active_cnt), 32'h0);
        for (int k = 0; k < 20; k++) step(2'd0, 4'b0011, 4'b0000, 4'b0000);
        chk("crit.latched", 32'(ch_state), 32'h924);
        step(2'd0, 4'b0011, 4'b0000, 4'b0010);
        chk("crit.clr_ch1", 32'(ch_state), 32'h904);

        // Grid code 3 is CRITICAL, and blocks fault clear while present.
        do_reset("g3");
        step(2'd0, 4'b0001, 4'b0000, 4'b0000);
        step(2'd0, 4'b0001, 4'b0000, 4'b0000);
        step(2'd3, 4'b0001, 4'b0000, 4'b0000);
        chk("g3.fault", 32'(ch_state), 32'h924);
        chk("g3.relay", 32'(relay), 32'h0);
        step(2'd3, 4'b0000, 4'b0000, 4'b1111);
        chk("g3.clr_blocked", 32'(ch_state), 32'h924);
        step(2'd0, 4'b0000, 4'b0000, 4'b1111);
        chk("g3.clr_ok", 32'(ch_state), 32'h000);

        // Asynchronous reset between edges while two channels charge.
        do_reset("arst");
        for (int k = 0; k < 6; k++) step(2'd0, 4'b0011, 4'b0000, 4'b0000);
        chk("arst.pre_ce", 32'(ce), 32'h3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst.state", 32'(ch_state), 32'h0);
        chk("arst.relay", 32'(relay), 32'h0);
        chk("arst.ce", 32'(ce), 32'h0);
        chk("arst.cnt", 32'(active_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Randomized traffic against the model.
        begin
            logic [1:0] g;
            logic [3:0] c, f, r;
            int         p;
            c = 4'($urandom);
            f = '0;
            for (int k = 0; k < 600; k++) begin
                p = int'($urandom_range(0, 99));
                g = (p < 75) ? 2'd0 : (p < 90) ? 2'd1 : (p < 96) ? 2'd2 : 2'd3;
                for (int i = 0; i < NC; i++) begin
                    if ($urandom_range(0, 9) == 0) c[i] = ~c[i];
                    f[i] = ($urandom_range(0, 19) == 0);
                    r[i] = ($urandom_range(0, 4) == 0);
                end
                step(g, c, f, r);
                chk_model("rnd");
                chk("rnd.cnt_cap", 32'(active_cnt <= 3'(MA)), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
